// File: rtl/mem_bist_pkg.sv
// mem_bist_pkg: shared types and the pattern generator for the memory test engine.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package mem_bist_pkg;

    // Widest data word the pattern function can produce; callers size-cast the result.
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        MODE_CLEAR   = 2'd0,
        MODE_ADDR    = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_ALL     = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_TURN  = 3'd2,
        ST_READ  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Data a healthy memory should hold at addr for the given pattern.
    // The caller zero-extends addr to MAX_W and truncates the result to its width.
    function automatic logic [MAX_W-1:0] expected_data(input mode_e pattern,
                                                       input logic [MAX_W-1:0] addr);
        logic [MAX_W-1:0] checker_word;
        logic [MAX_W-1:0] result;
        checker_word = {(MAX_W/2){2'b01}};
        case (pattern)
            MODE_ADDR:    result = addr;
            MODE_CHECKER: result = addr[0] ? ~checker_word : checker_word;
            default:      result = '0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/mem_bist_checker.sv
// mem_bist_checker: compares read-back data with the expected word, counts and records failures.
// Latency: compare lands on the edge ending the cycle after the read strobe.
// Backpressure: none; one compare per cycle, error count saturates instead of wrapping.
module mem_bist_checker
    import mem_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int ERR_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  rd_vld,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_exp,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic                  fail_valid,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic                  clean_nxt
);

    localparam logic [ERR_WIDTH-1:0] ERR_ONE = ERR_WIDTH'(1);

    logic                  pend_vld;
    logic [ADDR_WIDTH-1:0] pend_addr;
    logic [DATA_WIDTH-1:0] pend_exp;
    logic                  mismatch;

    // Memory returns data one cycle after the strobe, so the compare uses the held request.
    assign mismatch  = pend_vld && (mem_rdata != pend_exp);
    // Error count after this edge will still be zero: used to settle pass on entry to DONE.
    assign clean_nxt = (err_count == '0) && !mismatch;

    // Pending-read pipeline, saturating error counter and first-failure capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld   <= 1'b0;
            pend_addr  <= '0;
            pend_exp   <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_addr  <= '0;
        end else if (clear) begin
            pend_vld   <= 1'b0;
            pend_addr  <= '0;
            pend_exp   <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_addr  <= '0;
        end else begin
            pend_vld  <= rd_vld;
            pend_addr <= rd_addr;
            pend_exp  <= rd_exp;
            if (mismatch) begin
                if (!(&err_count)) begin
                    err_count <= err_count + ERR_ONE;
                end
                if (!fail_valid) begin
                    fail_valid <= 1'b1;
                    fail_addr  <= pend_addr;
                end
            end
        end
    end

endmodule

// File: rtl/mem_bist_ctrl.sv
// mem_bist_ctrl: write/read-back test engine for one single-port synchronous memory.
// Latency: 2*DEPTH+2 cycles per pattern plus one DONE cycle; ALL runs three patterns back to back.
// Backpressure: none; memory must take one access per cycle, start is ignored while busy.
module mem_bist_ctrl
    import mem_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int ERR_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            mode,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic                  fail_valid,
    output logic [ADDR_WIDTH-1:0] fail_addr
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    state_e                state, state_nxt;
    mode_e                 mode_q, mode_nxt;
    mode_e                 pattern, pattern_nxt;
    logic [ADDR_WIDTH-1:0] addr, addr_nxt;
    logic                  addr_last;
    logic                  start_acc;
    logic [DATA_WIDTH-1:0] wdata_nxt;
    logic [DATA_WIDTH-1:0] rd_exp;
    logic                  clean_nxt;

    // Terminal count is all-ones so the counter can wrap freely without an extra bit.
    assign addr_last = &addr;
    assign start_acc = (state == ST_IDLE) && start;
    assign mem_addr  = addr;

    // Write data is prepared for the next cycle so mem_wdata leaves a flop.
    assign wdata_nxt = DATA_WIDTH'(expected_data(pattern_nxt, MAX_W'(addr_nxt)));
    // Expected word for the read being issued this cycle, handed to the checker pipeline.
    assign rd_exp    = DATA_WIDTH'(expected_data(pattern, MAX_W'(addr)));

    // Sequencer state, latched mode, current pattern and address counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            mode_q  <= MODE_CLEAR;
            pattern <= MODE_CLEAR;
            addr    <= '0;
        end else begin
            state   <= state_nxt;
            mode_q  <= mode_nxt;
            pattern <= pattern_nxt;
            addr    <= addr_nxt;
        end
    end

    // Next-state, next-pattern and next-address decode.
    always_comb begin
        state_nxt   = state;
        mode_nxt    = mode_q;
        pattern_nxt = pattern;
        addr_nxt    = addr;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    mode_nxt    = mode_e'(mode);
                    pattern_nxt = ((mode == 2'd0) || (mode == 2'd3)) ? MODE_CLEAR : mode_e'(mode);
                    addr_nxt    = '0;
                    state_nxt   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                addr_nxt = addr + ADDR_ONE;
                if (addr_last) begin
                    state_nxt = ST_TURN;
                end
            end
            ST_TURN: begin
                addr_nxt  = '0;
                state_nxt = ST_READ;
            end
            ST_READ: begin
                addr_nxt = addr + ADDR_ONE;
                if (addr_last) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                addr_nxt = '0;
                if ((mode_q == MODE_ALL) && (pattern != MODE_CHECKER)) begin
                    pattern_nxt = mode_e'(pattern + 2'd1);
                    state_nxt   = ST_WRITE;
                end else begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered memory strobes and status, decoded from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            mem_read  <= (state_nxt == ST_READ);
            mem_write <= (state_nxt == ST_WRITE);
            mem_wdata <= (state_nxt == ST_WRITE) ? wdata_nxt : '0;
            busy      <= (state_nxt inside {ST_WRITE, ST_TURN, ST_READ, ST_DRAIN});
            done      <= (state_nxt == ST_DONE);
            if (start_acc) begin
                pass <= 1'b0;
            end else if (state_nxt == ST_DONE) begin
                pass <= clean_nxt;
            end
        end
    end

    mem_bist_checker #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ERR_WIDTH  (ERR_WIDTH)
    ) u_checker (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_acc),
        .rd_vld     (mem_read),
        .rd_addr    (mem_addr),
        .rd_exp     (rd_exp),
        .mem_rdata  (mem_rdata),
        .err_count  (err_count),
        .fail_valid (fail_valid),
        .fail_addr  (fail_addr),
        .clean_nxt  (clean_nxt)
    );

endmodule

// File: doc/mem_bist_ctrl.md
# mem_bist_ctrl

Synthesizable, parametrised memory test engine that drives a single-port synchronous memory through its read/write/addr/data ports and checks read-back against a selected pattern. It generalises the bench-level clear and data-equals-address tests to arbitrary width and depth, adds a checkerboard pattern and a run-all sequence, and reports pass/fail, a saturating error count and the first failing address. It sits between the top-level control (start/mode) and the memory under test, in place of a behavioural bench.

## Interface
- ADDR_WIDTH, 5: memory address width; DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 8: memory word width.
- ERR_WIDTH, 16: error counter width.

- clk  in  1  clock, all activity on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  begin test; sampled only in IDLE.
- mode  in  2  0 CLEAR, 1 ADDR, 2 CHECKER, 3 ALL (CLEAR→ADDR→CHECKER).
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  data to memory.
- mem_rdata  in  DATA_WIDTH  data from memory, valid the cycle after a read.
- busy  out  1  test in progress.
- done  out  1  one-cycle pulse at completion.
- pass  out  1  last test had zero errors; held until next start.
- err_count  out  ERR_WIDTH  mismatches, saturates at all-ones.
- fail_valid  out  1  at least one mismatch recorded.
- fail_addr  out  ADDR_WIDTH  address of first mismatch.

## Operation
- States: IDLE, WRITE, TURN, READ, DRAIN, DONE.
- IDLE: start=1 latches mode, clears err_count/fail_valid/fail_addr/pass, → WRITE with pattern = CLEAR if mode is 0 or 3, else mode.
- WRITE: mem_write=1, mem_addr counts 0..DEPTH-1, mem_wdata = expected(pattern, addr); after addr DEPTH-1 → TURN.
- TURN: one idle cycle, both strobes low, addr counter reset to 0 → READ.
- READ: mem_read=1, addr 0..DEPTH-1; compare pipelined one cycle behind. After DEPTH-1 → DRAIN.
- DRAIN: compares last address; if mode=ALL and pattern≠CHECKER, advance pattern and → WRITE; else → DONE.
- DONE: done=1, pass = (err_count==0), → IDLE.
- Expected data: CLEAR = 0; ADDR = addr zero-extended or truncated to DATA_WIDTH; CHECKER = 8'h55 replicated to DATA_WIDTH, bitwise inverted when addr[0]=1.
- Mismatch: err_count+1 (saturate); first mismatch sets fail_valid and fail_addr; later mismatches do not overwrite.
- start while busy is ignored; mode changes while busy are ignored.

## Timing
- Reset values: mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_addr=0, state IDLE.
- All outputs registered. busy rises the cycle after start is sampled, falls with done.
- Per pattern: DEPTH write + 1 TURN + DEPTH read + 1 DRAIN = 2·DEPTH+2 cycles; DONE adds 1. ALL = 3·(2·DEPTH+2)+1.
- Read issued in cycle n is compared against mem_rdata at the posedge ending cycle n+1.
- Address counter wraps naturally at DEPTH; terminal detection uses all-ones, not overflow.
- rst_n low mid-test: immediate return to reset values; no done pulse.

## Structure
- Package mem_bist_pkg: mode enum (CLEAR, ADDR, CHECKER, ALL), state enum, function expected_data(pattern, addr) parametrised by widths via the caller.
- Sub-module mem_bist_checker: registered compare of mem_rdata vs expected, saturating err_count, first-fail capture; cleared on start.

## Test plan
- Reset mid-WRITE (addr=10) → all outputs at reset values next cycle, no done.
- mode=0, good memory, defaults → done at cycle 67 after busy, pass=1, err_count=0.
- mode=1, memory with addr 7 bit 2 stuck-at-0 → err_count=1, fail_addr=7, pass=0 (data 7 reads 3).
- mode=2, DATA_WIDTH=16 → writes 16'h5555 at even, 16'hAAAA at odd addresses; clean pass.
- mode=3, addr 3 and 9 stuck at 8'hFF → err_count=6 (two per pattern), fail_addr=3.
- ERR_WIDTH=2, stuck data bus → err_count saturates at 3; start pulsed while busy is ignored.
